// File: rtl/poly_result_streamer.sv
// rtl/poly_result_streamer.sv - streams result-RAM coefficients out over a valid/ready port
module poly_result_streamer #(
    parameter int N  = 256,
    parameter int W  = 12,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bitrev,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [1:0]    state;
    logic [AW-1:0] ic;
    logic [AW-1:0] bc;
    logic [AW-1:0] ic_rev;
    logic          rev_q;
    logic          inflight;
    logic [1:0]    occ;
    logic [W-1:0]  head;
    logic [W-1:0]  tail;
    logic          pop;
    logic          issue;
    logic          launch;
    logic [2:0]    pending;

    // Buffer slots already spoken for: stored entries plus the read whose data lands next edge
    always_comb begin
        pending = {1'b0, occ} + {2'b00, inflight};
    end

    // Issue a read only when the 2-entry buffer is guaranteed a free slot for its data
    always_comb begin
        pop    = out_valid & out_ready;
        launch = (state == S_IDLE) & start;
        issue  = (state == S_STREAM) & ((pending - {2'b00, pop}) < 3'd2);
    end

    // Mirror the issue counter for bit-reversed traversal
    always_comb begin
        ic_rev = '0;
        for (int i = 0; i < AW; i++) begin
            ic_rev[i] = ic[AW-1-i];
        end
    end

    // Drive the RAM port; the address is parked at zero whenever no read is issued
    always_comb begin
        rd_en   = issue;
        rd_addr = issue ? (rev_q ? ic_rev : ic) : '0;
    end

    // Present the buffer head and status flags
    always_comb begin
        out_valid = (occ != 2'd0);
        out_data  = head;
        out_last  = out_valid & (bc == LAST_IDX);
        busy      = (state == S_STREAM) | (state == S_DRAIN);
        done      = (state == S_DONE);
    end

    // Transfer sequencing: issue phase, drain of buffered beats, one-cycle completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (issue && (ic == LAST_IDX)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (bc == LAST_IDX)) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Issue and beat counters, plus the read order captured when the transfer launches
    always_ff @(posedge clk) begin
        if (rst) begin
            ic    <= '0;
            bc    <= '0;
            rev_q <= 1'b0;
        end else if (launch) begin
            ic    <= '0;
            bc    <= '0;
            rev_q <= bitrev;
        end else begin
            if (issue) begin
                ic <= ic + 1'b1;
            end
            if (pop) begin
                bc <= bc + 1'b1;
            end
        end
    end

    // Remember a read issued this cycle so its data is captured on the next edge
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // Two-entry output buffer; head doubles as the registered output beat
    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (launch) begin
            occ <= 2'd0;
        end else begin
            case (occ)
                2'd0: begin
                    if (inflight) begin
                        head <= rd_data;
                        occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (inflight && pop) begin
                        head <= rd_data;
                    end else if (inflight) begin
                        tail <= rd_data;
                        occ  <= 2'd2;
                    end else if (pop) begin
                        occ <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (inflight) begin
                            tail <= rd_data;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/poly_result_streamer.md
# poly_result_streamer

Output-side reader for the polynomial multiplier. After the multiply/INTT datapath finishes writing the result coefficient RAM, this block reads all N coefficients through the RAM's synchronous read port. It emits them one per cycle on a valid/ready stream toward the host or testbench, in natural or bit-reversed index order. It is the counterpart of the serial coefficient loader that feeds `in1`/`in2` into the top.

## Interface

Parameters:
- `N`, 256: number of coefficients per polynomial; must be a power of two.
- `W`, 12: coefficient width in bits.
- `AW`, 8: address width; equals log2(N).

Ports:
- `clk`: input, 1 bit. Single clock.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `start`: input, 1 bit. Begins a transfer when sampled high in IDLE.
- `bitrev`: input, 1 bit. Sampled together with `start`. 1 selects bit-reversed read order.
- `rd_en`: output, 1 bit. Result-RAM read enable.
- `rd_addr`: output, AW bits. Result-RAM read address.
- `rd_data`: input, W bits. RAM data; valid exactly one cycle after `rd_en`.
- `out_data`: output, W bits. Streamed coefficient.
- `out_valid`: output, 1 bit. `out_data` is valid.
- `out_ready`: input, 1 bit. Consumer accepts the beat.
- `out_last`: output, 1 bit. High with the beat of index N-1.
- `busy`: output, 1 bit. A transfer is in progress.
- `done`: output, 1 bit. One-cycle pulse after the final beat is accepted.

## Operation

- States:
  - IDLE.
  - STREAM: reads are issued and beats are emitted.
  - DRAIN: all N reads have been issued; buffered beats are still emitted.
  - DONE: single cycle, then back to IDLE.
- IDLE→STREAM when `start`=1. This edge latches `bitrev`, clears the issue counter `ic`, clears the beat counter `bc`, and empties the buffer.
- Read issue in STREAM: assert `rd_en` when `occ + inflight − pop < 2`.
  - `occ` is the output-buffer occupancy (0..2).
  - `inflight` is 1 if `rd_en` was asserted in the previous cycle.
  - `pop` = `out_valid & out_ready`.
- `rd_addr` = `ic` when `bitrev`=0, otherwise `ic` with its AW bits reversed.
- `ic` increments on each issued read. STREAM→DRAIN on the cycle that issues read N-1.
- Output buffer: 2-entry FIFO.
  - `rd_data` is written on the cycle after `rd_en`.
  - `out_data`/`out_valid` present the FIFO head, registered.
- `bc` increments on every `pop`. `out_last` = `out_valid` & (`bc` == N-1).
- DRAIN→DONE on `pop` with `bc` == N-1. DONE asserts `done` for one cycle, then goes to IDLE.
- `busy` is 1 in STREAM and DRAIN; 0 in IDLE and DONE.
- `start` while not in IDLE is ignored; no restart, no effect on `bitrev`.
- Backpressure: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable. No beat is dropped or duplicated. Read issue stalls so the FIFO never overflows.
- Data passes through unmodified; there is no arithmetic on coefficients.
- Reset, including mid-transfer:
  - Next state is IDLE. `ic`, `bc` and `occ` clear to 0.
  - Any in-flight read is discarded.
  - All outputs are 0 on the cycle after `rst` is sampled high.

## Timing

- Reset values: `rd_en`=0, `rd_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
- Latency, with `start` sampled at edge 0:
  - `busy` and `rd_en` are high (address of index 0) in cycle 1.
  - `rd_data` arrives in cycle 2.
  - First `out_valid` is in cycle 3.
- Throughput: 1 beat/cycle while `out_ready`=1.
- With `out_ready` held high, beats occupy cycles 3..N+2, `out_last` is in cycle N+2, and `done` is in cycle N+3.
- After a stall, the first beat is re-presented with zero extra bubble once `out_ready` rises. Full rate resumes immediately, because the FIFO holds 2 entries.
- `start` may be asserted again in the cycle `done` is high. It is sampled in IDLE on the following cycle.

## Test plan

- Natural order: RAM[i]=i+1, `bitrev`=0, `out_ready`=1, pulse `start` → beats 1..256 in cycles 3..258 without gaps; `out_last` only with value 256; `done` in cycle 259; `busy` low from cycle 259.
- Bit-reversed order: same RAM, `bitrev`=1 → beat k carries RAM[rev8(k)]+… (beat 1 = 129, beat 2 = 65, beat 255 = 256); exactly 256 beats.
- Random backpressure: `out_ready` 50% random → the sequence still equals 1..256 exactly, `out_data` is stable whenever valid && !ready, and `rd_en` never causes `occ` > 2.
- Long stall: `out_ready`=0 for 10 cycles while beat 5 (value 6) is presented → value 6 holds for all 10 cycles; after `out_ready` rises, 6,7,8… follow on consecutive cycles.
- `start` while busy: pulse `start` at beat 50 with `bitrev`=1 → no effect; natural order continues; a single `done` pulse.
- Reset mid-stream: `rst` for 1 cycle at beat 100 → all outputs are 0 the next cycle and there is no `done`. A new `start` then streams from value 1 again.
